// File: rtl/xif_copro_pkg.sv
// Shared types and encodings for the XIF coprocessor: operation enum and
// custom-0 instruction field constants.
package xif_copro_pkg;

    typedef enum logic [1:0] {
        NONE     = 2'd0,
        BITREV   = 2'd1,
        ROTLEFT  = 2'd2,
        ROTRIGHT = 2'd3
    } copro_op_e;

    localparam logic [6:0] OPCODE_CUSTOM0  = 7'b0001011;
    localparam logic [2:0] FUNCT3_BITREV   = 3'b000;
    localparam logic [2:0] FUNCT3_ROTLEFT  = 3'b001;
    localparam logic [2:0] FUNCT3_ROTRIGHT = 3'b010;
    localparam logic [6:0] FUNCT7_COPRO    = 7'b0000000;

endpackage

// File: rtl/xif_copro_decoder.sv
// Combinational custom-0 decoder: instruction word to accept/writeback/operation.
module xif_copro_decoder
    import xif_copro_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic        accept_o,
    output logic        writeback_o,
    output copro_op_e   op_o
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_match;

    assign w_opcode = instr_i[6:0];
    assign w_funct3 = instr_i[14:12];
    assign w_funct7 = instr_i[31:25];
    assign w_match  = (w_opcode == OPCODE_CUSTOM0) && (w_funct7 == FUNCT7_COPRO);

    always_comb begin
        op_o = NONE;
        if (w_match) begin
            case (w_funct3)
                FUNCT3_BITREV:   op_o = BITREV;
                FUNCT3_ROTLEFT:  op_o = ROTLEFT;
                FUNCT3_ROTRIGHT: op_o = ROTRIGHT;
                default:         op_o = NONE;
            endcase
        end
    end

    assign accept_o    = (op_o != NONE);
    assign writeback_o = (op_o != NONE);

endmodule

// File: rtl/xif_copro_issue_stage.sv
// XIF issue/commit front end: decodes custom-0 instructions, holds them in an
// in-order buffer until committed or killed, then hands them to the ex stage.
module xif_copro_issue_stage
    import xif_copro_pkg::*;
#(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ID_WIDTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic [XLEN-1:0]     issue_rs1_i,
    input  logic [XLEN-1:0]     issue_rs2_i,
    output logic                issue_accept_o,
    output logic                issue_writeback_o,
    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,
    output logic                ex_valid_o,
    input  logic                ex_ready_i,
    output logic [XLEN-1:0]     ex_operand_a_o,
    output logic [XLEN-1:0]     ex_operand_b_o,
    output copro_op_e           ex_operator_o,
    output logic [ID_WIDTH-1:0] ex_tag_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    typedef struct packed {
        logic                valid;
        copro_op_e           op;
        logic [XLEN-1:0]     rs1;
        logic [XLEN-1:0]     rs2;
        logic [ID_WIDTH-1:0] id;
        logic                committed;
        logic                killed;
    } entry_t;

    entry_t           r_buf [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;

    logic             w_dec_accept;
    logic             w_dec_wb;
    copro_op_e        w_dec_op;
    logic [IDX_W-1:0] w_head_idx;
    logic [IDX_W-1:0] w_tail_idx;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_dispatch;
    logic             w_commit_new;
    entry_t           w_head;
    entry_t           w_new;

    xif_copro_decoder u_decoder (
        .instr_i     (issue_instr_i),
        .accept_o    (w_dec_accept),
        .writeback_o (w_dec_wb),
        .op_o        (w_dec_op)
    );

    assign issue_accept_o    = w_dec_accept;
    assign issue_writeback_o = w_dec_wb;

    assign w_head_idx = r_head[IDX_W-1:0];
    assign w_tail_idx = r_tail[IDX_W-1:0];
    assign w_empty    = (r_head == r_tail);
    assign w_full     = (r_head[IDX_W] != r_tail[IDX_W]) && (w_head_idx == w_tail_idx);
    assign w_head     = r_buf[w_head_idx];

    assign issue_ready_o = ~w_full;
    assign w_push        = issue_valid_i & ~w_full & w_dec_accept;

    // Killed heads retire without an ex handshake; live ones wait for ex_ready_i.
    assign w_dispatch = ~w_empty & w_head.committed & ~w_head.killed;
    assign w_pop      = ~w_empty & w_head.committed & (w_head.killed | ex_ready_i);

    // A commit for the id being issued this cycle lands on the new entry directly.
    assign w_commit_new = commit_valid_i && (commit_id_i == issue_id_i);

    always_comb begin
        w_new           = '0;
        w_new.valid     = 1'b1;
        w_new.op        = w_dec_op;
        w_new.rs1       = issue_rs1_i;
        w_new.rs2       = issue_rs2_i;
        w_new.id        = issue_id_i;
        w_new.committed = w_commit_new;
        w_new.killed    = w_commit_new & commit_kill_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_head <= '0;
            r_tail <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (commit_valid_i && r_buf[i].valid && (r_buf[i].id == commit_id_i)) begin
                    r_buf[i].committed <= 1'b1;
                    if (commit_kill_i) begin
                        r_buf[i].killed <= 1'b1;
                    end
                end
            end
            if (w_pop) begin
                r_buf[w_head_idx].valid <= 1'b0;
                r_head                  <= r_head + PTR_W'(1);
            end
            if (w_push) begin
                r_buf[w_tail_idx] <= w_new;
                r_tail            <= r_tail + PTR_W'(1);
            end
        end
    end

    always_comb begin
        ex_valid_o     = w_dispatch;
        ex_operand_a_o = '0;
        ex_operand_b_o = '0;
        ex_operator_o  = NONE;
        ex_tag_o       = '0;
        if (w_dispatch) begin
            ex_operand_a_o = w_head.rs1;
            ex_operand_b_o = w_head.rs2;
            ex_operator_o  = w_head.op;
            ex_tag_o       = w_head.id;
        end
    end

endmodule

// File: tb/tb_xif_copro_issue_stage.sv
// Directed testbench for xif_copro_issue_stage: decode, commit/kill ordering,
// backpressure, full condition and reset behaviour.
module tb_xif_copro_issue_stage;
    import xif_copro_pkg::*;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned ID_WIDTH = 4;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                issue_valid_i;
    logic                issue_ready_o;
    logic [31:0]         issue_instr_i;
    logic [ID_WIDTH-1:0] issue_id_i;
    logic [XLEN-1:0]     issue_rs1_i;
    logic [XLEN-1:0]     issue_rs2_i;
    logic                issue_accept_o;
    logic                issue_writeback_o;
    logic                commit_valid_i;
    logic [ID_WIDTH-1:0] commit_id_i;
    logic                commit_kill_i;
    logic                ex_valid_o;
    logic                ex_ready_i;
    logic [XLEN-1:0]     ex_operand_a_o;
    logic [XLEN-1:0]     ex_operand_b_o;
    copro_op_e           ex_operator_o;
    logic [ID_WIDTH-1:0] ex_tag_o;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    xif_copro_issue_stage #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .ID_WIDTH (ID_WIDTH)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .issue_valid_i     (issue_valid_i),
        .issue_ready_o     (issue_ready_o),
        .issue_instr_i     (issue_instr_i),
        .issue_id_i        (issue_id_i),
        .issue_rs1_i       (issue_rs1_i),
        .issue_rs2_i       (issue_rs2_i),
        .issue_accept_o    (issue_accept_o),
        .issue_writeback_o (issue_writeback_o),
        .commit_valid_i    (commit_valid_i),
        .commit_id_i       (commit_id_i),
        .commit_kill_i     (commit_kill_i),
        .ex_valid_o        (ex_valid_o),
        .ex_ready_i        (ex_ready_i),
        .ex_operand_a_o    (ex_operand_a_o),
        .ex_operand_b_o    (ex_operand_b_o),
        .ex_operator_o     (ex_operator_o),
        .ex_tag_o          (ex_tag_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mk_instr(input logic [2:0] f3);
        return {7'd0, 5'd2, 5'd1, f3, 5'd3, 7'b0001011};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        issue_valid_i  = 1'b0;
        commit_valid_i = 1'b0;
        commit_kill_i  = 1'b0;
    endtask

    task automatic drive_issue(input logic [31:0] instr, input logic [3:0] id,
                               input logic [63:0] rs1, input logic [63:0] rs2);
        issue_valid_i = 1'b1;
        issue_instr_i = instr;
        issue_id_i    = id;
        issue_rs1_i   = rs1;
        issue_rs2_i   = rs2;
    endtask

    task automatic drive_commit(input logic [3:0] id, input logic kill);
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
    endtask

    task automatic test_reset();
        idle();
        ex_ready_i = 1'b0;
        rst_ni     = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        n_tests++;
        if (issue_ready_o !== 1'b1 || ex_valid_o !== 1'b0 || ex_operator_o !== NONE ||
            ex_operand_a_o !== 64'd0 || ex_operand_b_o !== 64'd0 || ex_tag_o !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b valid=%b op=%0d a=%h b=%h tag=%0d, want ready=1 valid=0 op=0 a=0 b=0 tag=0",
                     issue_ready_o, ex_valid_o, ex_operator_o, ex_operand_a_o, ex_operand_b_o, ex_tag_o);
        end
    endtask

    task automatic test_decode();
        logic [31:0] instrs [6];
        logic        want   [6];
        instrs[0] = mk_instr(3'b000);             want[0] = 1'b1;
        instrs[1] = mk_instr(3'b001);             want[1] = 1'b1;
        instrs[2] = mk_instr(3'b010);             want[2] = 1'b1;
        instrs[3] = mk_instr(3'b011);             want[3] = 1'b0;
        instrs[4] = mk_instr(3'b000) | 32'h0200_0000; want[4] = 1'b0;
        instrs[5] = 32'h0000_0033;                want[5] = 1'b0;
        idle();
        for (int i = 0; i < 6; i++) begin
            issue_instr_i = instrs[i];
            #1;
            n_tests++;
            if (issue_accept_o !== want[i] || issue_writeback_o !== want[i]) begin
                n_fail++;
                $display("FAIL decode_%0d: accept=%b wb=%b, want %b", i, issue_accept_o, issue_writeback_o, want[i]);
            end
        end
    endtask

    task automatic test_basic();
        ex_ready_i = 1'b1;
        drive_issue(mk_instr(3'b000), 4'd3, 64'h1, 64'h2);
        drive_commit(4'd3, 1'b0);
        #1;
        n_tests++;
        if (issue_accept_o !== 1'b1 || issue_writeback_o !== 1'b1 || ex_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_issue: accept=%b wb=%b valid=%b, want 1 1 0", issue_accept_o, issue_writeback_o, ex_valid_o);
        end
        tick();
        idle();
        #1;
        n_tests++;
        if (ex_valid_o !== 1'b1 || ex_operator_o !== BITREV || ex_operand_a_o !== 64'h1 ||
            ex_operand_b_o !== 64'h2 || ex_tag_o !== 4'd3) begin
            n_fail++;
            $display("FAIL basic_dispatch: valid=%b op=%0d a=%h b=%h tag=%0d, want 1 op=1 a=1 b=2 tag=3",
                     ex_valid_o, ex_operator_o, ex_operand_a_o, ex_operand_b_o, ex_tag_o);
        end
        tick();
        n_tests++;
        if (ex_valid_o !== 1'b0 || ex_operator_o !== NONE || ex_operand_a_o !== 64'd0) begin
            n_fail++;
            $display("FAIL basic_empty: valid=%b op=%0d a=%h, want 0 0 0", ex_valid_o, ex_operator_o, ex_operand_a_o);
        end
    endtask

    task automatic test_reject();
        ex_ready_i = 1'b1;
        drive_issue(32'h0000_0033, 4'd7, 64'hAA, 64'hBB);
        #1;
        n_tests++;
        if (issue_accept_o !== 1'b0 || issue_writeback_o !== 1'b0 || issue_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reject_decode: accept=%b wb=%b ready=%b, want 0 0 1", issue_accept_o, issue_writeback_o, issue_ready_o);
        end
        tick();
        idle();
        drive_commit(4'd7, 1'b0);
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (ex_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reject_no_dispatch_%0d: valid=%b, want 0", i, ex_valid_o);
            end
            tick();
        end
    endtask

    task automatic test_kill();
        logic [3:0] want_tag [3];
        logic       want_vld [3];
        ex_ready_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive_issue(mk_instr(3'b001), 4'(i), 64'(i), 64'd0);
            tick();
        end
        idle();
        // commit 1 (kill), 2, 3 on consecutive cycles; expected ex state after each edge
        want_vld[0] = 1'b0; want_tag[0] = 4'd0;
        want_vld[1] = 1'b1; want_tag[1] = 4'd2;
        want_vld[2] = 1'b1; want_tag[2] = 4'd3;
        for (int i = 0; i < 3; i++) begin
            drive_commit(4'(i + 1), (i == 0));
            tick();
            idle();
            n_tests++;
            if (ex_valid_o !== want_vld[i] || ex_tag_o !== want_tag[i] ||
                (want_vld[i] && (ex_operator_o !== ROTLEFT || ex_operand_a_o !== 64'(want_tag[i])))) begin
                n_fail++;
                $display("FAIL kill_step_%0d: valid=%b tag=%0d op=%0d a=%h, want valid=%b tag=%0d",
                         i, ex_valid_o, ex_tag_o, ex_operator_o, ex_operand_a_o, want_vld[i], want_tag[i]);
            end
        end
        tick();
        n_tests++;
        if (ex_valid_o !== 1'b0 || issue_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL kill_drained: valid=%b ready=%b, want 0 1", ex_valid_o, issue_ready_o);
        end
    endtask

    task automatic test_full_backpressure();
        ex_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_issue(mk_instr(3'b010), 4'(8 + k), 64'h80 + 64'(k), 64'h5);
            drive_commit(4'(8 + k), 1'b0);
            tick();
            n_tests++;
            if (issue_ready_o !== (k != 3) || ex_valid_o !== 1'b1 || ex_tag_o !== 4'd8 ||
                ex_operand_a_o !== 64'h80 || ex_operator_o !== ROTRIGHT) begin
                n_fail++;
                $display("FAIL full_fill_%0d: ready=%b valid=%b tag=%0d a=%h op=%0d, want ready=%b valid=1 tag=8 a=80 op=3",
                         k, issue_ready_o, ex_valid_o, ex_tag_o, ex_operand_a_o, ex_operator_o, (k != 3));
            end
        end
        // offered while full: must not be stored
        drive_issue(mk_instr(3'b000), 4'd12, 64'hC, 64'hC);
        drive_commit(4'd12, 1'b0);
        tick();
        idle();
        tick();
        n_tests++;
        if (issue_ready_o !== 1'b0 || ex_valid_o !== 1'b1 || ex_tag_o !== 4'd8 || ex_operand_a_o !== 64'h80) begin
            n_fail++;
            $display("FAIL full_stall_stable: ready=%b valid=%b tag=%0d a=%h, want 0 1 8 80",
                     issue_ready_o, ex_valid_o, ex_tag_o, ex_operand_a_o);
        end
        ex_ready_i = 1'b1;
        tick();
        ex_ready_i = 1'b0;
        n_tests++;
        if (issue_ready_o !== 1'b1 || ex_valid_o !== 1'b1 || ex_tag_o !== 4'd9 || ex_operand_a_o !== 64'h81) begin
            n_fail++;
            $display("FAIL full_one_pop: ready=%b valid=%b tag=%0d a=%h, want 1 1 9 81",
                     issue_ready_o, ex_valid_o, ex_tag_o, ex_operand_a_o);
        end
        tick();
        ex_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (ex_valid_o !== 1'b1 || ex_tag_o !== 4'(9 + k)) begin
                n_fail++;
                $display("FAIL full_drain_%0d: valid=%b tag=%0d, want 1 %0d", k, ex_valid_o, ex_tag_o, 9 + k);
            end
            tick();
        end
        n_tests++;
        if (ex_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drained: valid=%b tag=%0d, want valid=0", ex_valid_o, ex_tag_o);
        end
    endtask

    task automatic test_ooo_commit();
        ex_ready_i = 1'b1;
        drive_issue(mk_instr(3'b000), 4'd5, 64'h55, 64'd0);
        tick();
        drive_issue(mk_instr(3'b000), 4'd6, 64'h66, 64'd0);
        tick();
        idle();
        drive_commit(4'd6, 1'b0);
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (ex_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL ooo_stall_%0d: valid=%b tag=%0d, want valid=0", i, ex_valid_o, ex_tag_o);
            end
            tick();
        end
        drive_commit(4'd5, 1'b0);
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (ex_valid_o !== 1'b1 || ex_tag_o !== 4'(5 + i) || ex_operand_a_o !== (i == 0 ? 64'h55 : 64'h66)) begin
                n_fail++;
                $display("FAIL ooo_order_%0d: valid=%b tag=%0d a=%h, want 1 %0d", i, ex_valid_o, ex_tag_o, ex_operand_a_o, 5 + i);
            end
            tick();
        end
        n_tests++;
        if (ex_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ooo_drained: valid=%b, want 0", ex_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        ex_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive_issue(mk_instr(3'b001), 4'(k), 64'h100 + 64'(k), 64'd0);
            drive_commit(4'(k), 1'b0);
            tick();
            n_tests++;
            if (ex_valid_o !== 1'b1 || ex_tag_o !== 4'(k) || ex_operand_a_o !== 64'h100 + 64'(k) || issue_ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_%0d: valid=%b tag=%0d a=%h ready=%b, want 1 %0d %h 1",
                         k, ex_valid_o, ex_tag_o, ex_operand_a_o, issue_ready_o, k, 64'h100 + 64'(k));
            end
        end
        idle();
        tick();
        n_tests++;
        if (ex_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drained: valid=%b, want 0", ex_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        ex_ready_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive_issue(mk_instr(3'b000), 4'(i), 64'hF0, 64'd0);
            tick();
        end
        idle();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        n_tests++;
        if (ex_valid_o !== 1'b0 || issue_ready_o !== 1'b1 || ex_operator_o !== NONE || ex_tag_o !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid_state: valid=%b ready=%b op=%0d tag=%0d, want 0 1 0 0",
                     ex_valid_o, issue_ready_o, ex_operator_o, ex_tag_o);
        end
        drive_commit(4'd1, 1'b0);
        tick();
        idle();
        n_tests++;
        if (ex_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_lost: valid=%b tag=%0d, want valid=0", ex_valid_o, ex_tag_o);
        end
    endtask

    initial begin
        rst_ni        = 1'b0;
        issue_instr_i = '0;
        issue_id_i    = '0;
        issue_rs1_i   = '0;
        issue_rs2_i   = '0;
        commit_id_i   = '0;
        ex_ready_i    = 1'b0;
        idle();
        test_reset();
        test_decode();
        test_basic();
        test_reject();
        test_kill();
        test_full_backpressure();
        test_ooo_commit();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xif_copro_issue_stage.md
# xif_copro_issue_stage

Front end of the XIF coprocessor. Terminates the CPU-side XIF issue and commit transactions and decodes custom-0 instructions into `xif_copro_pkg::copro_op_e`. Accepted instructions wait in an in-order buffer until the CPU commits or kills them. Committed, non-killed instructions are then driven into `xif_copro_ex_stage` through its `in_valid`/`in_ready` handshake.

## Interface

Parameters:
- `XLEN`, 64, operand width; must match `xif_copro_ex_stage`.
- `DEPTH`, 4, buffer entries; power of two, ≥2.
- `ID_WIDTH`, 4, XIF instruction id width; also used as the ex-stage `tag_t`.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; synchronous, active-low.
- `issue_valid_i`  in  1  CPU issue request.
- `issue_ready_o`  out  1  issue can be taken.
- `issue_instr_i`  in  32  instruction word.
- `issue_id_i`  in  `ID_WIDTH`  instruction id.
- `issue_rs1_i`, `issue_rs2_i`  in  `XLEN`  register operands.
- `issue_accept_o`  out  1  instruction is a coprocessor instruction; valid during the issue handshake.
- `issue_writeback_o`  out  1  instruction will write rd; valid during the issue handshake.
- `commit_valid_i`  in  1  commit transaction.
- `commit_id_i`  in  `ID_WIDTH`  committed id.
- `commit_kill_i`  in  1  discard the instruction.
- `ex_valid_o`  out  1  instruction to the ex stage.
- `ex_ready_i`  in  1  ex stage ready.
- `ex_operand_a_o`, `ex_operand_b_o`  out  `XLEN`  rs1, rs2.
- `ex_operator_o`  out  `copro_op_e`  decoded operation.
- `ex_tag_o`  out  `ID_WIDTH`  instruction id.

## Operation

Decode (combinational):
- Match condition: opcode `7'b0001011` and funct7 `0`.
- funct3 000 → BITREV; 001 → ROTLEFT; 010 → ROTRIGHT.
- On a match: `issue_accept_o=1`, `issue_writeback_o=1`.
- Anything else: both outputs 0 and operator NONE.

Issue:
- Handshake is `issue_valid_i & issue_ready_o`.
- `issue_ready_o = ~full`. It does not depend on decode and has no bypass when full.
- Accepted instructions are written at the tail as {op, rs1, rs2, id, committed=0, killed=0}.
- Rejected instructions complete the handshake but are not stored.

Commit:
- A commit matches every valid entry whose id equals `commit_id_i`.
- It sets `committed`, and also sets `killed` if `commit_kill_i` is high.
- A commit for an id not present (e.g. a rejected instruction) is ignored.
- A commit in the same cycle as the issue of the same id applies to the entry being written.

Dispatch (in order, head only):
- Head valid & committed & ~killed → `ex_valid_o=1`, with ex outputs driven from the head entry.
- The head pops on `ex_valid_o & ex_ready_i`.
- Head valid & committed & killed → dropped in one cycle, with no ex handshake.
- Head uncommitted → stall; younger entries never bypass it.
- Push and pop in the same cycle are both performed; occupancy is unchanged.

## Timing

Reset (`rst_ni` low at a clock edge, including mid-operation):
- The buffer empties and all entries are cleared; pending uncommitted instructions are lost.
- Outputs: `issue_ready_o=1`, `ex_valid_o=0`, ex operands/tag 0, operator NONE.

Latency:
- Issue and commit in cycle N → `ex_valid_o` in cycle N+1 at the earliest.
- Commit arriving after issue in cycle M → `ex_valid_o` in M+1.

Stability:
- While `ex_valid_o & ~ex_ready_i`, all ex outputs hold stable.
- `ex_valid_o` never drops without a handshake, except on reset.

Boundary conditions:
- Empty: `ex_valid_o=0`, operator NONE, operands 0.
- Full: `issue_ready_o` goes low the cycle after the `DEPTH`-th accept.
- Pointer wrap: head and tail pointers are `$clog2(DEPTH)+1` bits; wrap is modulo `DEPTH`.
- Killed entries: a run of k killed entries at the head drains in k cycles.

## Structure

- Shared package `xif_copro_pkg`:
  - `copro_op_e` (NONE, BITREV, ROTLEFT, ROTRIGHT).
  - New constants `OPCODE_CUSTOM0`, `FUNCT3_BITREV`, `FUNCT3_ROTLEFT`, `FUNCT3_ROTRIGHT`, `FUNCT7_COPRO`.
- Buffer entry struct: local typedef, parameterized by `XLEN` and `ID_WIDTH`.
- Sub-module: `xif_copro_decoder` (pure combinational, instruction word → accept/writeback/op), reusable by future stages.

## Test plan

- **Basic:** issue BITREV id 3 with rs1=`64'h1` and commit id 3 in the same cycle → next cycle `ex_valid_o=1`, operator BITREV, operand_a=`64'h1`, tag 3.
- **Reject:** issue `32'h00000033` (ADD) → `issue_accept_o=0`, `issue_writeback_o=0`. A later commit of that id is ignored; `ex_valid_o` stays 0.
- **Kill:** issue ids 1, 2, 3; commit 1 (kill), 2, 3 → id 1 is never presented; ids 2 and 3 dispatch in order.
- **Full and backpressure:**
  - Hold `ex_ready_i=0` and issue 4 accepted instructions → `issue_ready_o=0`.
  - Raise `ex_ready_i` for one cycle → one pop; `issue_ready_o=1` the next cycle.
  - Ex outputs stay stable throughout the stall.
- **Out-of-order commit arrival:** issue ids 5, 6; commit 6 before 5 → nothing dispatches until 5 is committed, then 5 dispatches before 6.
- **Reset mid-operation:** 3 entries pending, `rst_ni=0` for one edge → buffer empty, `ex_valid_o=0`, `issue_ready_o=1`.
